// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline control types and defaults
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_e;

    localparam int NSTAGE_DEF = 5;

endpackage

// File: rtl/stall_decode.sv
// rtl/stall_decode.sv - priority decode of per-stage stall requests into hold/bubble vectors
module stall_decode #(
    parameter int NSTAGE = cpu_pkg::NSTAGE_DEF
) (
    input  logic [NSTAGE-1:0] stall_req_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] bubble_o
);

    // A stage is held when it or any older stage requests a stall; the bubble
    // goes into the first stage past the oldest requester.
    for (genvar j = 0; j < NSTAGE; j++) begin : g_stall
        assign stall_o[j] = |stall_req_i[NSTAGE-1:j];
    end

    assign bubble_o[0] = 1'b0;
    for (genvar j = 1; j < NSTAGE; j++) begin : g_bubble
        assign bubble_o[j] = stall_req_i[j-1] & ~stall_o[j];
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush sequencer with watchdog; PIPELINE_CTRL_PERF_EN adds perf counters
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int NSTAGE      = NSTAGE_DEF,
    parameter int FLUSH_STAGE = 2,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NSTAGE-1:0] stall_req_i,
    input  logic              flush_req_i,
    input  logic [31:0]       flush_pc_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] bubble_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic              redirect_o,
    output logic [31:0]       redirect_pc_o,
    output logic              busy_o,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
`endif
    output logic              timeout_o
);

    localparam logic [NSTAGE-1:0] FLUSH_MASK = NSTAGE'((64'd1 << (FLUSH_STAGE + 1)) - 64'd2);
    localparam logic [NSTAGE-1:0] KEEP_MASK  = ~NSTAGE'((64'd1 << (FLUSH_STAGE + 1)) - 64'd1);
    localparam int                WD_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_MAX     = WD_W'(TIMEOUT);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic              r_pend_vld;
    logic [31:0]       r_pend_pc;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_timeout;
    logic [NSTAGE-1:0] w_dec_stall;
    logic [NSTAGE-1:0] w_dec_bubble;
    logic              w_stall_any;
    logic              w_capture;

    stall_decode #(.NSTAGE(NSTAGE)) u_stall_decode (
        .stall_req_i (stall_req_i),
        .stall_o     (w_dec_stall),
        .bubble_o    (w_dec_bubble)
    );

    assign w_stall_any = |stall_req_i;
    // The oldest request wins: nothing new is taken while one is queued or being issued.
    assign w_capture   = flush_req_i && !r_pend_vld && (r_state != ST_FLUSH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        stall_o       = w_dec_stall;
        bubble_o      = w_dec_bubble;
        flush_o       = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = 32'h0;
        busy_o        = (r_state != ST_RUN);
        case (r_state)
            ST_RUN: begin
                if (w_stall_any) begin
                    w_state_nxt = ST_STALL;
                end else if (flush_req_i) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_STALL: begin
                if (!w_stall_any) begin
                    w_state_nxt = (r_pend_vld || flush_req_i) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                w_state_nxt   = ST_RUN;
                stall_o       = w_dec_stall & KEEP_MASK;
                bubble_o      = w_dec_bubble & KEEP_MASK;
                flush_o       = FLUSH_MASK;
                redirect_o    = 1'b1;
                redirect_pc_o = r_pend_pc;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_vld <= 1'b0;
            r_pend_pc  <= 32'h0;
        end else if (r_state == ST_FLUSH) begin
            r_pend_vld <= 1'b0;
        end else if (w_capture) begin
            r_pend_vld <= 1'b1;
            r_pend_pc  <= flush_pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (TIMEOUT != 0) begin
            if (w_stall_any) begin
                if (r_wd_cnt != WD_MAX) begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                end
                if (r_wd_cnt >= WD_MAX - 1'b1) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    assign timeout_o = r_timeout;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (|stall_o) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (r_state == ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (|bubble_o) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign flush_cnt_o  = r_flush_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed vector bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int NS = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] stall_req;
    logic          flush_req;
    logic [31:0]   flush_pc;
    logic [NS-1:0] stall_o, bubble_o, flush_o;
    logic          redirect, busy, timeout;
    logic [31:0]   redirect_pc;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0]   stall_cnt, flush_cnt, bubble_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.NSTAGE(NS), .FLUSH_STAGE(2), .TIMEOUT(8), .CNT_W(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_req_i   (stall_req),
        .flush_req_i   (flush_req),
        .flush_pc_i    (flush_pc),
        .stall_o       (stall_o),
        .bubble_o      (bubble_o),
        .flush_o       (flush_o),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc),
        .busy_o        (busy),
`ifdef PIPELINE_CTRL_PERF_EN
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt),
        .bubble_cnt_o  (bubble_cnt),
`endif
        .timeout_o     (timeout)
    );

    typedef struct {
        logic [NS-1:0] req;
        logic          fl;
        logic [31:0]   pc;
        logic [NS-1:0] e_stall;
        logic [NS-1:0] e_bub;
        logic [NS-1:0] e_flush;
        logic          e_redir;
        logic [31:0]   e_pc;
        logic          e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [NS-1:0] req, logic fl, logic [31:0] pc,
                                logic [NS-1:0] es, logic [NS-1:0] eb, logic [NS-1:0] ef,
                                logic er, logic [31:0] ep, logic ebusy);
        vec_t v;
        v.req = req; v.fl = fl; v.pc = pc;
        v.e_stall = es; v.e_bub = eb; v.e_flush = ef;
        v.e_redir = er; v.e_pc = ep; v.e_busy = ebusy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1: drive inputs, compare mid-cycle, advance to next posedge+1.
    task automatic apply(string tag, logic [NS-1:0] req, logic fl, logic [31:0] pc,
                         logic [NS-1:0] es, logic [NS-1:0] eb, logic [NS-1:0] ef,
                         logic er, logic [31:0] ep, logic ebusy, logic eto);
        stall_req = req;
        flush_req = fl;
        flush_pc  = pc;
        #4;
        chk({tag, ".stall"},  32'(stall_o),  32'(es));
        chk({tag, ".bubble"}, 32'(bubble_o), 32'(eb));
        chk({tag, ".flush"},  32'(flush_o),  32'(ef));
        chk({tag, ".redir"},  32'(redirect), 32'(er));
        chk({tag, ".rpc"},    redirect_pc,   ep);
        chk({tag, ".busy"},   32'(busy),     32'(ebusy));
        chk({tag, ".tmo"},    32'(timeout),  32'(eto));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        stall_req = '0;
        flush_req = 1'b0;
        flush_pc  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // stall from EX for 3 cycles, then release
        vecs.push_back(mk(5'b00100, 0, 0,            5'b00111, 5'b01000, 0, 0, 0, 0));
        vecs.push_back(mk(5'b00100, 0, 0,            5'b00111, 5'b01000, 0, 0, 0, 1));
        vecs.push_back(mk(5'b00100, 0, 0,            5'b00111, 5'b01000, 0, 0, 0, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 0));
        // flush in RUN
        vecs.push_back(mk(5'b00000, 1, 32'hBFC00380, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 5'b00110, 1, 32'hBFC00380, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 0));
        // flush together with a 4-cycle MEM stall
        vecs.push_back(mk(5'b01000, 1, 32'h12345678, 5'b01111, 5'b10000, 0, 0, 0, 0));
        vecs.push_back(mk(5'b01000, 0, 0,            5'b01111, 5'b10000, 0, 0, 0, 1));
        vecs.push_back(mk(5'b01000, 0, 0,            5'b01111, 5'b10000, 0, 0, 0, 1));
        vecs.push_back(mk(5'b01000, 0, 0,            5'b01111, 5'b10000, 0, 0, 0, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 5'b00110, 1, 32'h12345678, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 0));
        // two flushes while stalled: older wins, single redirect
        vecs.push_back(mk(5'b00010, 1, 32'h100,      5'b00011, 5'b00100, 0, 0, 0, 0));
        vecs.push_back(mk(5'b00010, 1, 32'h200,      5'b00011, 5'b00100, 0, 0, 0, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 5'b00110, 1, 32'h100, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 0));
        // WB stall arriving during FLUSH: low bits masked, request during FLUSH ignored
        vecs.push_back(mk(5'b00000, 1, 32'hAAAA0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5'b10000, 1, 32'hDEAD0000, 5'b11000, 0, 5'b00110, 1, 32'hAAAA0000, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 0));
        // IF stall during FLUSH: its hold and bubble both fall in the killed range
        vecs.push_back(mk(5'b00000, 1, 32'h44,       0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5'b00001, 0, 0,            0, 0, 5'b00110, 1, 32'h44, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 0));
        // WB stall in RUN: no bubble past the last stage
        vecs.push_back(mk(5'b10000, 0, 0,            5'b11111, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(5'b00000, 0, 0,            0, 0, 0, 0, 0, 0));

        do_reset();
        apply("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i].req, vecs[i].fl, vecs[i].pc,
                  vecs[i].e_stall, vecs[i].e_bub, vecs[i].e_flush,
                  vecs[i].e_redir, vecs[i].e_pc, vecs[i].e_busy, 1'b0);
        end

        // reset while a flush is pending in STALL discards it
        apply("rst_a", 5'b01000, 1, 32'h300, 5'b01111, 5'b10000, 0, 0, 0, 0, 0);
        apply("rst_b", 5'b01000, 0, 0,       5'b01111, 5'b10000, 0, 0, 0, 1, 0);
        rst       = 1'b1;
        stall_req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply("rst_c", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply("rst_d", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // watchdog: two 7-cycle stalls separated by an idle cycle never trip it
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 7; i++) begin
                apply($sformatf("wd7_%0d_%0d", r, i), 5'b00100, 0, 0, 5'b00111, 5'b01000,
                      0, 0, 0, (i > 0), 0);
            end
            apply($sformatf("wd7_idle%0d", r), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        apply("wd7_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 8 consecutive stalled cycles set the sticky flag
        for (int i = 0; i < 8; i++) begin
            apply($sformatf("wd8_%0d", i), 5'b00100, 0, 0, 5'b00111, 5'b01000,
                  0, 0, 0, (i > 0), 0);
        end
        apply("wd8_set",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        apply("wd8_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply("wd8_sticky2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        apply("wd8_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
